// File: rtl/i8080_sys_ctrl.sv
// i8080_sys_ctrl: bus controller sitting directly behind the i8080 core.
// Captures the status byte during sync and decodes the machine-cycle type.
// Runs a level req / pulse ack handshake to memory or I/O port space and
// holds cpu_ready low until the access completes. Returns read data (or the
// interrupt vector on INTA) onto the core data bus.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   cpu_data            core data bus: status/write data in, read data out
//   cpu_addr            core address
//   cpu_sync            status valid on cpu_data
//   cpu_dbin            core ready to receive data
//   cpu_write_n         core write strobe, low = write data valid
//   cpu_ready           low stalls the core
//   status_q            latched status byte
//   halted              HLTA cycle taken
//   bus_err             sticky: timeout, or sync seen mid-access
//   mem_*               memory request channel
//   io_*                port-space request channel, io_port = low address byte
module i8080_sys_ctrl #(
    parameter int              XLEN        = 8,
    parameter int              WAIT_STATES = 0,
    parameter int              TIMEOUT     = 255,
    parameter logic [XLEN-1:0] INTA_VECTOR = 8'hFF
) (
    input  logic                clk,
    input  logic                rst,
    inout  wire  [XLEN-1:0]     cpu_data,
    input  logic [2*XLEN-1:0]   cpu_addr,
    input  logic                cpu_sync,
    input  logic                cpu_dbin,
    input  logic                cpu_write_n,
    output logic                cpu_ready,
    output logic [XLEN-1:0]     status_q,
    output logic                halted,
    output logic                bus_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [2*XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_ack,
    output logic                io_req,
    output logic                io_we,
    output logic [XLEN-1:0]     io_port,
    output logic [XLEN-1:0]     io_wdata,
    input  logic [XLEN-1:0]     io_rdata,
    input  logic                io_ack
);

    localparam int WAIT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [TMO_W-1:0]  TMO_INIT  = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
    localparam logic              TMO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_WR = 2'd1,
        ST_REQ     = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CYC_NOP   = 3'd0,
        CYC_INTA  = 3'd1,
        CYC_HLTA  = 3'd2,
        CYC_IORD  = 3'd3,
        CYC_IOWR  = 3'd4,
        CYC_MEMRD = 3'd5,
        CYC_MEMWR = 3'd6
    } cyc_e;

    // Status byte decode in priority order INTA > HLTA > INP > OUT > MEMR > !WO_n.
    function automatic cyc_e decode_status(input logic [XLEN-1:0] st);
        cyc_e t;
        if (st[0])       t = CYC_INTA;
        else if (st[3])  t = CYC_HLTA;
        else if (st[6])  t = CYC_IORD;
        else if (st[4])  t = CYC_IOWR;
        else if (st[7])  t = CYC_MEMRD;
        else if (!st[1]) t = CYC_MEMWR;
        else             t = CYC_NOP;
        return t;
    endfunction

    // Cycle types that need a req/ack handshake and therefore stall the core.
    function automatic logic is_access(input cyc_e t);
        return (t == CYC_IORD) || (t == CYC_IOWR) || (t == CYC_MEMRD) || (t == CYC_MEMWR);
    endfunction

    state_e              state_r, state_n_s;
    cyc_e                type_r, dec_type_s;
    logic [XLEN-1:0]     status_r, wdata_r, rd_r;
    logic [2*XLEN-1:0]   addr_r;
    logic                halted_r, bus_err_r, ready_r, acked_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [TMO_W-1:0]    tmo_cnt_r;
    logic                sync_take_s, in_access_s, is_io_s, is_rd_s;
    logic                req_s, ack_s, wait_zero_s, tmo_exp_s, abort_s, done_s, drive_s;

    // Handshake strobes derived from current state and latched cycle type.
    always_comb begin
        dec_type_s  = decode_status(cpu_data);
        is_io_s     = (type_r == CYC_IORD) || (type_r == CYC_IOWR);
        is_rd_s     = (type_r == CYC_IORD) || (type_r == CYC_MEMRD);
        sync_take_s = cpu_sync && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        in_access_s = (state_r == ST_WAIT_WR) || (state_r == ST_REQ);
        // req stays up only until the first ack; later acks are ignored
        req_s       = (state_r == ST_REQ) && !acked_r;
        if (is_io_s) begin
            ack_s = req_s && io_ack;
        end else begin
            ack_s = req_s && mem_ack;
        end
        wait_zero_s = (wait_cnt_r == {WAIT_W{1'b0}});
        // Abort on the edge where the counter would reach zero; ack in that same cycle wins.
        tmo_exp_s   = TMO_EN && (tmo_cnt_r <= TMO_ONE);
        abort_s     = req_s && !ack_s && tmo_exp_s;
        done_s      = (state_r == ST_REQ) && acked_r && wait_zero_s;
        drive_s     = (state_r == ST_DONE) && cpu_dbin && cpu_write_n && !cpu_sync &&
                      (is_rd_s || (type_r == CYC_INTA));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (cpu_sync) begin
                    case (dec_type_s)
                        CYC_IORD, CYC_MEMRD: state_n_s = ST_REQ;
                        CYC_IOWR, CYC_MEMWR: state_n_s = ST_WAIT_WR;
                        default:             state_n_s = ST_DONE;
                    endcase
                end else begin
                    state_n_s = state_r;
                end
            end
            ST_WAIT_WR: begin
                if (!cpu_write_n) begin
                    state_n_s = ST_REQ;
                end else begin
                    state_n_s = ST_WAIT_WR;
                end
            end
            ST_REQ: begin
                if (done_s || abort_s) begin
                    state_n_s = ST_DONE;
                end else begin
                    state_n_s = ST_REQ;
                end
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // Datapath: status/address/data latches, counters, ready and error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            type_r     <= CYC_NOP;
            status_r   <= {XLEN{1'b0}};
            addr_r     <= {2*XLEN{1'b0}};
            wdata_r    <= {XLEN{1'b0}};
            rd_r       <= {XLEN{1'b0}};
            halted_r   <= 1'b0;
            bus_err_r  <= 1'b0;
            ready_r    <= 1'b1;
            acked_r    <= 1'b0;
            wait_cnt_r <= {WAIT_W{1'b0}};
            tmo_cnt_r  <= {TMO_W{1'b0}};
        end else begin
            if (sync_take_s) begin
                status_r   <= cpu_data;
                addr_r     <= cpu_addr;
                type_r     <= dec_type_s;
                halted_r   <= (dec_type_s == CYC_HLTA);
                ready_r    <= !is_access(dec_type_s);
                acked_r    <= 1'b0;
                wait_cnt_r <= WAIT_INIT;
                tmo_cnt_r  <= TMO_INIT;
                if (dec_type_s == CYC_INTA) begin
                    rd_r <= INTA_VECTOR;
                end
            end else if (in_access_s) begin
                // saturating down-counters, never wrap
                if (!wait_zero_s) begin
                    wait_cnt_r <= wait_cnt_r - WAIT_ONE;
                end
                if (tmo_cnt_r != {TMO_W{1'b0}}) begin
                    tmo_cnt_r <= tmo_cnt_r - TMO_ONE;
                end
            end
            if ((state_r == ST_WAIT_WR) && !cpu_write_n) begin
                wdata_r <= cpu_data;
            end
            if (ack_s) begin
                acked_r <= 1'b1;
                if (is_rd_s) begin
                    rd_r <= is_io_s ? io_rdata : mem_rdata;
                end
            end
            if (abort_s) begin
                rd_r      <= {XLEN{1'b1}};
                bus_err_r <= 1'b1;
            end
            if (done_s || abort_s) begin
                ready_r <= 1'b1;
            end
            // a new sync while an access is outstanding is a protocol violation
            if (cpu_sync && in_access_s) begin
                bus_err_r <= 1'b1;
            end
        end
    end

    assign cpu_data  = drive_s ? rd_r : {XLEN{1'bz}};
    assign cpu_ready = ready_r;
    assign status_q  = status_r;
    assign halted    = halted_r;
    assign bus_err   = bus_err_r;
    assign mem_req   = req_s && !is_io_s;
    assign io_req    = req_s && is_io_s;
    assign mem_we    = mem_req && (type_r == CYC_MEMWR);
    assign io_we     = io_req && (type_r == CYC_IOWR);
    assign mem_addr  = addr_r;
    assign io_port   = addr_r[XLEN-1:0];
    assign mem_wdata = wdata_r;
    assign io_wdata  = wdata_r;

endmodule

// File: tb/tb_i8080_sys_ctrl.sv
// Self-checking bench for i8080_sys_ctrl: directed bus cycles followed by
// randomized ones, checked against a cycle-count model of the controller.
module tb_i8080_sys_ctrl;

    localparam int WS  = 2;
    localparam int TMO = 6;

    logic        clk = 1'b0;
    logic        rst;
    wire  [7:0]  cpu_data;
    logic [7:0]  tb_data;
    logic        tb_drv;
    logic [15:0] cpu_addr;
    logic        cpu_sync, cpu_dbin, cpu_write_n;
    logic        cpu_ready, halted, bus_err;
    logic [7:0]  status_q;
    logic        mem_req, mem_we, mem_ack, io_req, io_we, io_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata, io_port, io_wdata, io_rdata;

    int   checks = 0;
    int   errors = 0;
    logic err_exp = 1'b0;

    assign cpu_data = tb_drv ? tb_data : 8'hzz;

    always #5 clk = ~clk;

    i8080_sys_ctrl #(.XLEN(8), .WAIT_STATES(WS), .TIMEOUT(TMO), .INTA_VECTOR(8'hFF)) dut (
        .clk(clk), .rst(rst), .cpu_data(cpu_data), .cpu_addr(cpu_addr),
        .cpu_sync(cpu_sync), .cpu_dbin(cpu_dbin), .cpu_write_n(cpu_write_n),
        .cpu_ready(cpu_ready), .status_q(status_q), .halted(halted), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .io_req(io_req), .io_we(io_we), .io_port(io_port), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Cycle kind from the status byte: 0 NOP 1 INTA 2 HLTA 3 IN 4 OUT 5 MEMR 6 MEMW
    function automatic int classify(input logic [7:0] st);
        if (st[0] == 1'b1) return 1;
        if (st[3] == 1'b1) return 2;
        if (st[6] == 1'b1) return 3;
        if (st[4] == 1'b1) return 4;
        if (st[7] == 1'b1) return 5;
        if (st[1] == 1'b0) return 6;
        return 0;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One complete bus cycle. w = edge (after sync edge 0) where write data is
    // strobed, k = edge where ack is presented (0 = never), viol = edge of a
    // stray sync (0 = none). Called right after a falling edge.
    task automatic run_txn(input logic [7:0] st, input logic [15:0] addr, input int w,
                           input int k, input logic [7:0] rdat, input logic [7:0] wdat,
                           input int viol);
        int   kind, rstart, a_edge, d_edge, req_end;
        logic access, is_wr, is_rd, is_io, taken, exp_req;
        logic [7:0] rd_exp;
        kind   = classify(st);
        access = (kind >= 3);
        is_wr  = (kind == 4) || (kind == 6);
        is_rd  = (kind == 3) || (kind == 5);
        is_io  = (kind == 3) || (kind == 4);
        rstart = is_wr ? w : 0;
        a_edge = max2(TMO, rstart + 1);
        taken  = access && (k > rstart) && (k <= a_edge);
        d_edge = !access ? 0 : (taken ? max2(k, WS) + 1 : a_edge);
        req_end = taken ? k : a_edge;
        rd_exp = (kind == 1) ? 8'hFF : (taken ? rdat : 8'hFF);
        if (access && !taken) err_exp = 1'b1;
        if (access && viol > 0 && viol < d_edge) err_exp = 1'b1;

        cpu_sync = 1'b1; tb_drv = 1'b1; tb_data = st; cpu_addr = addr;
        cpu_write_n = 1'b1; cpu_dbin = 1'b0; mem_ack = 1'b0; io_ack = 1'b0;
        for (int m = 0; m <= d_edge; m++) begin
            @(negedge clk);
            exp_req = access && (m >= rstart) && (m < req_end);
            check_eq("ready", cpu_ready, (access && m < d_edge) ? 1'b0 : 1'b1);
            check_eq("mem_req", mem_req, exp_req && !is_io);
            check_eq("io_req", io_req, exp_req && is_io);
            if (exp_req) begin
                if (is_io) begin
                    check_eq("io_port", io_port, addr[7:0]);
                    check_eq("io_we", io_we, is_wr);
                    if (is_wr) check_eq("io_wdata", io_wdata, wdat);
                end else begin
                    check_eq("mem_addr", mem_addr, addr);
                    check_eq("mem_we", mem_we, is_wr);
                    if (is_wr) check_eq("mem_wdata", mem_wdata, wdat);
                end
            end
            // inputs for edge m+1
            cpu_sync    = access && (m + 1 == viol);
            cpu_write_n = !(is_wr && (m + 1 == w));
            tb_drv      = 1'b0;
            if (!cpu_write_n) begin
                tb_drv = 1'b1; tb_data = wdat;
            end else if (cpu_sync) begin
                tb_drv = 1'b1; tb_data = 8'($urandom);
            end
            mem_ack   = access && !is_io && (m + 1 == k);
            io_ack    = access && is_io && (m + 1 == k);
            mem_rdata = (m + 1 == k) ? rdat : 8'($urandom);
            io_rdata  = (m + 1 == k) ? rdat : 8'($urandom);
        end
        @(negedge clk);
        cpu_sync = 1'b0; tb_drv = 1'b0; cpu_write_n = 1'b1; mem_ack = 1'b0; io_ack = 1'b0;
        check_eq("ready_done", cpu_ready, 1'b1);
        check_eq("req_done", mem_req | io_req, 1'b0);
        check_eq("status_q", status_q, st);
        check_eq("halted", halted, kind == 2);
        check_eq("bus_err", bus_err, err_exp);
        cpu_dbin = 1'b1;
        #1;
        if (is_rd || kind == 1) check_eq("rd_data", cpu_data, rd_exp);
        cpu_dbin = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, expected finish earlier");
        $fatal(1);
    end

    initial begin
        logic [7:0] bases [7];
        logic [7:0] st;
        int b, w, k, viol, d;
        bases[0] = 8'h02; bases[1] = 8'h23; bases[2] = 8'h8A; bases[3] = 8'h42;
        bases[4] = 8'h10; bases[5] = 8'hA2; bases[6] = 8'h00;

        rst = 1'b0; tb_drv = 1'b0; tb_data = 8'h00; cpu_addr = 16'h0000;
        cpu_sync = 1'b0; cpu_dbin = 1'b0; cpu_write_n = 1'b1;
        mem_ack = 1'b0; io_ack = 1'b0; mem_rdata = 8'h00; io_rdata = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", cpu_ready, 1'b1);
        check_eq("rst_status", status_q, 8'h00);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_bus_err", bus_err, 1'b0);
        check_eq("rst_req", {mem_req, io_req, mem_we, io_we}, 4'b0000);
        check_eq("rst_addr", mem_addr, 16'h0000);
        rst = 1'b1;
        @(negedge clk);

        // directed cycles
        run_txn(8'hA2, 16'h1234, 0, 2, 8'h3E, 8'h00, 0);   // mem read
        run_txn(8'h00, 16'h2000, 1, 2, 8'h00, 8'h55, 0);   // mem write, wait states dominate
        run_txn(8'h42, 16'h0707, 0, 1, 8'h9C, 8'h00, 0);   // io in
        run_txn(8'h10, 16'h0033, 2, 5, 8'h00, 8'hAA, 0);   // io out, ack after wait states
        run_txn(8'h23, 16'h0038, 0, 0, 8'h00, 8'h00, 0);   // INTA
        run_txn(8'h8A, 16'h0100, 0, 0, 8'h00, 8'h00, 0);   // HLTA
        run_txn(8'h02, 16'h0200, 0, 0, 8'h00, 8'h00, 0);   // NOP clears halted
        run_txn(8'hA2, 16'h4321, 0, TMO, 8'h77, 8'h00, 0); // ack on the expiry edge wins
        run_txn(8'hA2, 16'h4444, 0, 0, 8'h00, 8'h00, 0);   // timeout
        run_txn(8'hA2, 16'h5555, 0, TMO + 1, 8'h11, 8'h00, 0); // late ack after abort

        // reset in the middle of a request
        cpu_sync = 1'b1; tb_drv = 1'b1; tb_data = 8'hA2; cpu_addr = 16'h6666;
        @(negedge clk);
        cpu_sync = 1'b0; tb_drv = 1'b0;
        check_eq("mid_req_up", mem_req, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        err_exp = 1'b0;
        check_eq("mid_rst_req", mem_req, 1'b0);
        check_eq("mid_rst_ready", cpu_ready, 1'b1);
        check_eq("mid_rst_err", bus_err, 1'b0);
        check_eq("mid_rst_status", status_q, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_txn(8'hA2, 16'h7777, 0, 4, 8'hC3, 8'h00, 2);   // stray sync mid-access
        run_txn(8'h8A, 16'h0000, 0, 0, 8'h00, 8'h00, 0);

        // randomized cycles
        for (int n = 0; n < 80; n++) begin
            b  = $urandom_range(0, 6);
            st = bases[b] | (8'($urandom) & 8'h24);
            w  = 0; k = 0; viol = 0;
            if (b == 4 || b == 6) begin
                w = $urandom_range(1, 3);
                k = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(w + 1, w + TMO);
                d = (k > 0 && k <= TMO) ? max2(k, WS) + 1 : TMO;
            end else if (b == 3 || b == 5) begin
                k = $urandom_range(0, TMO + 1);
                d = (k > 0 && k <= TMO) ? max2(k, WS) + 1 : TMO;
            end else begin
                d = 0;
            end
            if (d >= 2 && $urandom_range(0, 5) == 0) viol = $urandom_range(1, d - 1);
            run_txn(st, 16'($urandom), w, k, 8'($urandom), 8'($urandom), viol);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                @(negedge clk);
                check_eq("idle_ready", cpu_ready, 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
